// File: rtl/mips_exec_stage.sv
// MIPS EX stage: ALU, overflow/illegal traps, valid/ready to ID and MEM, flush.
// Define EXEC_MUL_EN to build the iterative multiplier for alu_op 4'hE.
module mips_exec_stage #(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 5,
   parameter int MUL_STEP = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_op,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic [XLEN-1:0]   store_data,
   input  logic [REG_AW-1:0] dest_reg,
   input  logic              mem_en,
   input  logic              mem_write,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   result,
   output logic [REG_AW-1:0] out_dest_reg,
   output logic              out_mem_en,
   output logic              out_mem_write,
   output logic [XLEN-1:0]   out_store_data,
   output logic              ovf_exc,
   output logic              illegal_exc
);

   localparam int SH = $clog2(XLEN);

   if ((XLEN % MUL_STEP) != 0 || XLEN < 8) begin : g_bad_cfg
      $error("mips_exec_stage: bad XLEN/MUL_STEP");
   end

   typedef enum logic [1:0] {
      EMPTY,
      BUSY,
      FULL
   } state_t;

   state_t state, state_nxt;

   logic            accept;
   logic            is_mul;
   logic            trap;
   logic            alu_ovf;
   logic            alu_ill;
   logic            slt;
   logic            sltu;
   logic [SH-1:0]   shamt;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic [XLEN-1:0] alu_res;
   logic            ovf_r;
   logic            ill_r;

`ifdef EXEC_MUL_EN
   localparam int NSTEP = XLEN / MUL_STEP;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc_nxt;
   logic            mul_done;

   assign is_mul   = (alu_op == 4'hE);
   assign mul_done = (state == BUSY) && (cnt == '0);
   // one radix-2^MUL_STEP digit of op_b per cycle, low bits first
   assign acc_nxt  = acc + mcand *
      {{(XLEN-MUL_STEP){1'b0}}, mplier[MUL_STEP-1:0]};
`else
   assign is_mul = 1'b0;
`endif

   assign in_ready = !flush &&
      (state == EMPTY || (state == FULL && out_ready));
   assign accept   = in_valid && in_ready;
   assign out_valid   = (state == FULL);
   assign ovf_exc     = out_valid && ovf_r;
   assign illegal_exc = out_valid && ill_r;

   assign sum   = op_a + op_b;
   assign diff  = op_a - op_b;
   assign shamt = op_a[SH-1:0];
   assign slt   = $signed(op_a) < $signed(op_b);
   assign sltu  = op_a < op_b;
   assign trap  = alu_ovf || alu_ill;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (alu_op)
         4'h0: begin
            alu_res = sum;
            alu_ovf = (op_a[XLEN-1] == op_b[XLEN-1]) &&
                      (sum[XLEN-1] != op_a[XLEN-1]);
         end
         4'h1: alu_res = sum;
         4'h2: begin
            alu_res = diff;
            alu_ovf = (op_a[XLEN-1] != op_b[XLEN-1]) &&
                      (diff[XLEN-1] != op_a[XLEN-1]);
         end
         4'h3: alu_res = diff;
         4'h4: alu_res = op_a & op_b;
         4'h5: alu_res = op_a | op_b;
         4'h6: alu_res = op_a ^ op_b;
         4'h7: alu_res = ~(op_a | op_b);
         4'h8: alu_res = {{(XLEN-1){1'b0}}, slt};
         4'h9: alu_res = {{(XLEN-1){1'b0}}, sltu};
         4'hA: alu_res = op_b << shamt;
         4'hB: alu_res = op_b >> shamt;
         4'hC: alu_res = $signed(op_b) >>> shamt;
         4'hD: alu_res = op_b << (XLEN / 2);
`ifdef EXEC_MUL_EN
         4'hE: alu_res = '0;
`else
         4'hE: alu_ill = 1'b1;
`endif
         default: alu_res = op_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (accept) state_nxt = is_mul ? BUSY : FULL;
         end
         BUSY: begin
`ifdef EXEC_MUL_EN
            if (mul_done) state_nxt = FULL;
`else
            state_nxt = EMPTY;
`endif
         end
         FULL: begin
            if (out_ready) begin
               if (accept) state_nxt = is_mul ? BUSY : FULL;
               else        state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush) state_nxt = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result         <= '0;
         out_dest_reg   <= '0;
         out_mem_en     <= 1'b0;
         out_mem_write  <= 1'b0;
         out_store_data <= '0;
         ovf_r          <= 1'b0;
         ill_r          <= 1'b0;
      end else if (accept) begin
         // side-band fields are latched at accept, even for a multiply
         out_dest_reg   <= trap ? '0 : dest_reg;
         out_mem_en     <= trap ? 1'b0 : mem_en;
         out_mem_write  <= mem_write;
         out_store_data <= store_data;
         ovf_r          <= alu_ovf;
         ill_r          <= alu_ill;
         if (!is_mul) result <= alu_res;
      end
`ifdef EXEC_MUL_EN
      else if (mul_done && !flush) begin
         result <= acc_nxt;
      end
`endif
   end

`ifdef EXEC_MUL_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (accept && is_mul) begin
         cnt    <= CW'(NSTEP - 1);
         acc    <= '0;
         mcand  <= op_a;
         mplier <= op_b;
      end else if (state == BUSY) begin
         acc    <= acc_nxt;
         mcand  <= mcand << MUL_STEP;
         mplier <= mplier >> MUL_STEP;
         if (cnt != '0) cnt <= cnt - 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_exec_stage.sv
// Directed self-checking bench for mips_exec_stage (XLEN=32, MUL_STEP=4).
// Follows EXEC_MUL_EN in the same way as the design.
module tb_mips_exec_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] store_data;
   logic [4:0]  dest_reg;
   logic        mem_en;
   logic        mem_write;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  out_dest_reg;
   logic        out_mem_en;
   logic        out_mem_write;
   logic [31:0] out_store_data;
   logic        ovf_exc;
   logic        illegal_exc;

   int passed = 0;
   int total  = 0;

   mips_exec_stage #(.XLEN(32), .REG_AW(5), .MUL_STEP(4)) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .alu_op(alu_op),
      .op_a(op_a),
      .op_b(op_b),
      .store_data(store_data),
      .dest_reg(dest_reg),
      .mem_en(mem_en),
      .mem_write(mem_write),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .out_dest_reg(out_dest_reg),
      .out_mem_en(out_mem_en),
      .out_mem_write(out_mem_write),
      .out_store_data(out_store_data),
      .ovf_exc(ovf_exc),
      .illegal_exc(illegal_exc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d);
      in_valid   = 1'b1;
      alu_op     = op;
      op_a       = a;
      op_b       = b;
      dest_reg   = d;
      mem_en     = 1'b0;
      mem_write  = 1'b0;
      store_data = 32'h0;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      issue(4'h0, 0, 0, 0);
      idle();
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_dest", 32'(out_dest_reg), 32'd0);
      check("rst_memen", 32'(out_mem_en), 32'd0);
      check("rst_exc", 32'({ovf_exc, illegal_exc}), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);

      // basic ADD, then overflow trap, then ADDU without trap
      issue(4'h0, 32'd5, 32'd7, 5'd3);
      tick();
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_res", result, 32'd12);
      check("add_dest", 32'(out_dest_reg), 32'd3);
      check("add_ovf", 32'(ovf_exc), 32'd0);

      issue(4'h0, 32'h7FFF_FFFF, 32'd1, 5'd4);
      mem_en = 1'b1;
      tick();
      check("addov_res", result, 32'h8000_0000);
      check("addov_ovf", 32'(ovf_exc), 32'd1);
      check("addov_dest", 32'(out_dest_reg), 32'd0);
      check("addov_memen", 32'(out_mem_en), 32'd0);

      issue(4'h1, 32'h7FFF_FFFF, 32'd1, 5'd4);
      mem_en = 1'b1; mem_write = 1'b1; store_data = 32'hABC;
      tick();
      check("addu_res", result, 32'h8000_0000);
      check("addu_ovf", 32'(ovf_exc), 32'd0);
      check("addu_dest", 32'(out_dest_reg), 32'd4);
      check("addu_mem", 32'({out_mem_en, out_mem_write}), 32'd3);
      check("addu_sd", out_store_data, 32'hABC);

      idle();
      tick();
      check("drain_valid", 32'(out_valid), 32'd0);

      // backpressure: first op held, second waits
      out_ready = 1'b0;
      issue(4'h0, 32'd1, 32'd2, 5'd5);
      #1;
      check("bp_rdy_empty", 32'(in_ready), 32'd1);
      tick();
      issue(4'h5, 32'hF0, 32'h0F, 5'd6);
      #1;
      check("bp_rdy_full", 32'(in_ready), 32'd0);
      tick(); tick();
      check("bp_hold_res", result, 32'd3);
      check("bp_hold_dest", 32'(out_dest_reg), 32'd5);
      check("bp_hold_v", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      #1;
      check("bp_rdy_rel", 32'(in_ready), 32'd1);
      tick();
      idle();
      check("bp_second_res", result, 32'hFF);
      check("bp_second_dest", 32'(out_dest_reg), 32'd6);
      check("bp_second_v", 32'(out_valid), 32'd1);
      tick();
      check("bp_empty", 32'(out_valid), 32'd0);

      // back-to-back ALU ops
      issue(4'hC, 32'd4, 32'h8000_0000, 5'd1);
      tick();
      check("sra", result, 32'hF800_0000);
      issue(4'h9, 32'd1, 32'hFFFF_FFFF, 5'd1);
      tick();
      check("sltu", result, 32'd1);
      issue(4'h8, 32'd1, 32'hFFFF_FFFF, 5'd1);
      tick();
      check("slt", result, 32'd0);
      issue(4'hD, 32'd0, 32'h1234, 5'd1);
      tick();
      check("lui", result, 32'h1234_0000);
      issue(4'hA, 32'd36, 32'd1, 5'd1);
      tick();
      check("sll_mask", result, 32'h10);
      issue(4'hB, 32'd8, 32'h8000_0000, 5'd1);
      tick();
      check("srl", result, 32'h0080_0000);
      issue(4'h2, 32'h8000_0000, 32'd1, 5'd2);
      tick();
      check("subov_res", result, 32'h7FFF_FFFF);
      check("subov_ovf", 32'(ovf_exc), 32'd1);
      issue(4'h3, 32'd3, 32'd5, 5'd2);
      tick();
      check("subu", result, 32'hFFFF_FFFE);
      check("subu_ovf", 32'(ovf_exc), 32'd0);
      issue(4'h7, 32'h0, 32'hF, 5'd2);
      tick();
      check("nor", result, 32'hFFFF_FFF0);
      issue(4'h6, 32'hFF00, 32'h0FF0, 5'd2);
      tick();
      check("xor", result, 32'hF0F0);
      issue(4'hF, 32'h1, 32'hCAFE, 5'd2);
      tick();
      check("passb", result, 32'hCAFE);
      idle();
      tick();

`ifdef EXEC_MUL_EN
      issue(4'hE, 32'd6, 32'd7, 5'd7);
      tick();
      idle();
      for (int i = 0; i < 8; i++) begin
         check("mul_busy_rdy", 32'(in_ready), 32'd0);
         check("mul_busy_v", 32'(out_valid), 32'd0);
         tick();
      end
      check("mul_valid", 32'(out_valid), 32'd1);
      check("mul_res", result, 32'd42);
      check("mul_dest", 32'(out_dest_reg), 32'd7);
      tick();

      issue(4'hE, 32'd3, 32'd3, 5'd8);
      tick();
      idle();
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_v", 32'(out_valid), 32'd0);
      for (int i = 0; i < 10; i++) tick();
      check("flush_v_late", 32'(out_valid), 32'd0);
      check("flush_rdy", 32'(in_ready), 32'd1);
`else
      issue(4'hE, 32'd6, 32'd7, 5'd7);
      mem_en = 1'b1;
      tick();
      idle();
      check("ill_valid", 32'(out_valid), 32'd1);
      check("ill_exc", 32'(illegal_exc), 32'd1);
      check("ill_res", result, 32'd0);
      check("ill_dest", 32'(out_dest_reg), 32'd0);
      check("ill_memen", 32'(out_mem_en), 32'd0);
      tick();
      check("ill_drain", 32'(illegal_exc), 32'd0);

      out_ready = 1'b0;
      issue(4'h0, 32'd1, 32'd1, 5'd8);
      tick();
      issue(4'h5, 32'd1, 32'd2, 5'd8);
      flush = 1'b1;
      #1;
      check("flush_rdy0", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      idle();
      check("flush_v", 32'(out_valid), 32'd0);
      tick();
      check("flush_v_late", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
`endif

      // reset while FULL
      out_ready = 1'b0;
      issue(4'h1, 32'd1, 32'd1, 5'd9);
      mem_en = 1'b1; mem_write = 1'b1; store_data = 32'h55;
      tick();
      idle();
      check("pre_rst_v", 32'(out_valid), 32'd1);
      reset = 1'b1;
      tick();
      check("rst2_v", 32'(out_valid), 32'd0);
      check("rst2_res", result, 32'd0);
      check("rst2_sd", out_store_data, 32'd0);
      check("rst2_dest", 32'(out_dest_reg), 32'd0);
      check("rst2_mem", 32'({out_mem_en, out_mem_write}), 32'd0);
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
